// File: rtl/commit_trace_buf_if.sv
// commit_trace_buf_if: commit-event capture and trace-drain signals for commit_trace_buf
interface commit_trace_buf_if #(parameter int AW = 4);
  logic [31:0] pc;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [AW:0] count;
  logic        overflow;
  logic [15:0] drop_cnt;
  modport master (
    output pc, grf_we, grf_addr, grf_wd, dm_we, dm_addr, dm_wd, out_ready,
    input  out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, drop_cnt
  );
  modport slave (
    input  pc, grf_we, grf_addr, grf_wd, dm_we, dm_addr, dm_wd, out_ready,
    output out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, drop_cnt
  );
endinterface

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: FWFT FIFO of core commit events (GRF/DM writes) with drop counting; COMMIT_TRACE_DM_EN enables DM capture
module commit_trace_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic clk,
  input logic reset,
  commit_trace_buf_if.slave bus
);
`ifdef COMMIT_TRACE_DM_EN
  localparam int W = 97;
`else
  localparam int W = 96;
`endif
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  logic [16:0]   drop_sum;
  logic          g_ev, push_req, conflict, pop, push, full_drop;
  logic [W-1:0]  entry, head;
  assign g_ev = bus.grf_we && bus.grf_addr != 5'd0;
`ifdef COMMIT_TRACE_DM_EN
  assign push_req = g_ev || bus.dm_we;
  assign conflict = g_ev && bus.dm_we;
  assign entry    = g_ev ? {1'b0, bus.pc, 27'd0, bus.grf_addr, bus.grf_wd}
                         : {1'b1, bus.pc, bus.dm_addr, bus.dm_wd};
`else
  logic unused_dm;
  assign unused_dm = ^{bus.dm_we, bus.dm_addr, bus.dm_wd};
  assign push_req  = g_ev;
  assign conflict  = 1'b0;
  assign entry     = {bus.pc, 27'd0, bus.grf_addr, bus.grf_wd};
`endif
  assign pop       = cnt_q != '0 && bus.out_ready;
  assign push      = push_req && (cnt_q != (AW+1)'(DEPTH) || pop);
  assign full_drop = push_req && !push;
  // Next-state: occupancy, pointers and saturating drop accounting
  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(conflict) + 17'(full_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d    = ovf_q | conflict | full_drop;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wp_d     = wp_q + AW'(push);
    rp_d     = rp_q + AW'(pop);
  end
  // Control state; reset drops queued entries and ignores this cycle's events
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end
  // Storage is never cleared; only pushes outside reset write it
  always_ff @(posedge clk) begin
    if (reset && push) mem[wp_q] <= entry;
  end
  assign head          = mem[rp_q];
  assign bus.out_valid = cnt_q != '0;
`ifdef COMMIT_TRACE_DM_EN
  assign {bus.out_kind, bus.out_pc, bus.out_addr, bus.out_data} = bus.out_valid ? head : '0;
`else
  assign bus.out_kind = 1'b0;
  assign {bus.out_pc, bus.out_addr, bus.out_data} = bus.out_valid ? head : '0;
`endif
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: doc/commit_trace_buf.md
# commit_trace_buf

Commit-event trace buffer sitting directly downstream of the single-cycle `mips` core. Each cycle it captures the core's architectural side effects (GRF write, DM write), tags them with the committing PC, and queues them in a FIFO. A testbench monitor or UART formatter drains the FIFO through a valid/ready port. Overflow is counted, never silently lost.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `AW`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; state clears on a rising edge of `clk` while `reset`=0.
- `pc`  in  32  PC of the instruction committing this cycle.
- `grf_we`  in  1  GRF write strobe.
- `grf_addr`  in  5  GRF destination register.
- `grf_wd`  in  32  GRF write data.
- `dm_we`  in  1  DM write strobe.
- `dm_addr`  in  32  DM byte address.
- `dm_wd`  in  32  DM write data.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head this cycle.
- `out_kind`  out  1  0 = GRF entry, 1 = DM entry.
- `out_pc`  out  32  entry PC.
- `out_addr`  out  32  GRF entry: `{27'b0, grf_addr}`; DM entry: `dm_addr`.
- `out_data`  out  32  write data.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set on the first dropped event.
- `drop_cnt`  out  16  dropped-event counter, saturating at 16'hFFFF.

## Operation

Event qualification, evaluated each cycle:
- GRF event: `grf_we`=1 and `grf_addr`≠0. Writes to $0 are filtered: no push and no drop.
- DM event: `dm_we`=1.
- Both events in the same cycle: the GRF event is the candidate push. The DM event is a drop: `drop_cnt`+1, `overflow`←1.
- At most one push per cycle.

FIFO:
- Storage is `DEPTH` × 97 bits: {kind, pc, addr, data}.
- Write and read pointers are AW bits and wrap modulo `DEPTH`.
- `count` is held as a register, not derived from the pointers.
- Push is accepted when `count`<`DEPTH`, or when `count`=`DEPTH` and a pop occurs in the same cycle.
- A push rejected because the FIFO is full is a drop: `drop_cnt`+1 (saturating), `overflow`←1.
- If a conflict drop and a full drop happen in the same cycle, `drop_cnt` increments by 2, still saturating.
- Pop occurs when `out_valid`=1 and `out_ready`=1.
- Push and pop in the same cycle leave `count` unchanged.
- `out_ready` has no effect when the FIFO is empty.

Output:
- First-word fall-through: `out_*` always present the head entry.
- When `count`=0, `out_kind`, `out_pc`, `out_addr` and `out_data` are driven to 0.
- `out_valid` = (`count`≠0).

Reset:
- `out_valid`=0, `count`=0, `overflow`=0, `drop_cnt`=0.
- Pointers are 0 and all `out_*` data outputs are 0.
- Storage contents are not cleared.
- Reset asserted mid-stream discards all queued entries and ignores that cycle's events.
- `overflow` clears only on reset.

## Timing

- An event presented in cycle N appears at the outputs from cycle N+1. If the FIFO was empty, `out_valid` rises in N+1.
- Pop at the edge ending cycle N: the next entry, or the empty state, is visible in cycle N+1.
- Sustained throughput is 1 push and 1 pop per cycle.
- `count`, `overflow` and `drop_cnt` are registered and reflect the previous edge.
- No combinational path from `out_ready` to any output.

## Configuration

Macro `COMMIT_TRACE_DM_EN`:
- Defined: DM events are captured as described above.
- Undefined:
  - `dm_we`, `dm_addr` and `dm_wd` are ignored.
  - `out_kind` is tied to 0.
  - Same-cycle conflict drops cannot occur.
  - Storage width reduces to 96 bits.

## Test plan

- Reset, then `grf_we`=1, `grf_addr`=8, `grf_wd`=32'h0000_1234, `pc`=32'h0000_3000 for 1 cycle with `out_ready`=0 → next cycle `out_valid`=1, `out_kind`=0, `out_addr`=8, `out_data`=32'h1234, `count`=1.
- `grf_we`=1 with `grf_addr`=0 for 5 cycles → `count` stays 0 and `drop_cnt` stays 0.
- `out_ready`=0 and 20 consecutive GRF events into a `DEPTH`=16 FIFO → `count`=16, `overflow`=1, `drop_cnt`=4. Then drain with `out_ready`=1 → 16 entries in push order, then `out_valid`=0.
- FIFO full and `out_ready`=1 with a new event in the same cycle → no drop; `count` stays 16; the new entry is the last one popped.
- `grf_we`=1 and `dm_we`=1 in the same cycle (macro defined) → one GRF entry pushed, `drop_cnt`=1. With the macro undefined → one GRF entry pushed, `drop_cnt`=0.
- Reset (`reset`=0) while `count`=7 → next cycle `count`=0, `out_valid`=0, `overflow` and `drop_cnt` cleared.
